// File: rtl/core_fetch_if.sv
// core_fetch_if: PC inputs, imem req/gnt/rvalid port and decode valid/ready port of core_fetch
interface core_fetch_if #(parameter int WORD_ADDR_WIDTH = 30);
  logic                       fetch_en_i;
  logic                       flush_i;
  logic [WORD_ADDR_WIDTH-1:0] pc_waddr_i;
  logic [WORD_ADDR_WIDTH-1:0] next_pc_waddr_i;
  logic                       pc_incr_o;
  logic                       imem_req_o;
  logic [WORD_ADDR_WIDTH-1:0] imem_addr_o;
  logic                       imem_gnt_i;
  logic                       imem_rvalid_i;
  logic [31:0]                imem_rdata_i;
  logic                       instr_valid_o;
  logic [31:0]                instr_o;
  logic [WORD_ADDR_WIDTH-1:0] instr_pc_waddr_o;
  logic                       instr_ready_i;
  modport slave (
    input  fetch_en_i, flush_i, pc_waddr_i, next_pc_waddr_i, imem_gnt_i, imem_rvalid_i,
           imem_rdata_i, instr_ready_i,
    output pc_incr_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_waddr_o
  );
  modport master (
    output fetch_en_i, flush_i, pc_waddr_i, next_pc_waddr_i, imem_gnt_i, imem_rvalid_i,
           imem_rdata_i, instr_ready_i,
    input  pc_incr_o, imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_waddr_o
  );
endinterface

// File: rtl/core_fetch.sv
// core_fetch: single-outstanding instruction fetch with flush and discard of in-flight data
module core_fetch #(
  parameter int WORD_ADDR_WIDTH = 30
) (
  input logic          clk_i,
  input logic          rst_i,
  core_fetch_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, DISCARD} state_t;
  state_t                     state_q, state_d;
  logic [WORD_ADDR_WIDTH-1:0] addr_q, addr_d, instr_pc_q, instr_pc_d;
  logic [31:0]                instr_q, instr_d;
  logic                       accept;
  assign accept = (state_q == VALID) & bus.instr_ready_i;
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      IDLE: if (bus.fetch_en_i & ~bus.flush_i) begin
        state_d = REQ;
        addr_d  = bus.pc_waddr_i;
      end
      REQ: begin
        if (bus.flush_i) state_d = bus.imem_gnt_i ? DISCARD : IDLE;
        else if (bus.imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (bus.flush_i) state_d = bus.imem_rvalid_i ? IDLE : DISCARD;
        else if (bus.imem_rvalid_i) begin
          state_d    = VALID;
          instr_d    = bus.imem_rdata_i;
          instr_pc_d = addr_q;
        end
      end
      VALID: begin
        if (bus.flush_i) state_d = IDLE;
        else if (accept) begin
          state_d = bus.fetch_en_i ? REQ : IDLE;
          addr_d  = bus.fetch_en_i ? bus.next_pc_waddr_i : addr_q;
        end
      end
      DISCARD: state_d = bus.imem_rvalid_i ? IDLE : DISCARD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end
  // Gated by rst_i so the handshake outputs are quiet during reset, even on the first edge
  assign bus.imem_req_o       = (state_q == REQ) & ~rst_i;
  assign bus.instr_valid_o    = (state_q == VALID) & ~rst_i;
  assign bus.pc_incr_o        = accept & ~bus.flush_i & ~rst_i;
  assign bus.imem_addr_o      = addr_q;
  assign bus.instr_o          = instr_q;
  assign bus.instr_pc_waddr_o = instr_pc_q;
endmodule

// File: tb/tb_core_fetch.sv
// tb_core_fetch: directed scenarios for core_fetch with hand-computed expectations
module tb_core_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  core_fetch_if #(.WORD_ADDR_WIDTH(30)) bus ();
  core_fetch #(.WORD_ADDR_WIDTH(30)) dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.fetch_en_i = 1'b0; bus.flush_i = 1'b0; bus.pc_waddr_i = 30'h100; bus.next_pc_waddr_i = 30'h101;
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'h0; bus.instr_ready_i = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    #1;
    n_checks++; if ({bus.imem_req_o, bus.instr_valid_o, bus.pc_incr_o} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b exp 000", {bus.imem_req_o, bus.instr_valid_o, bus.pc_incr_o}); end
    n_checks++; if ({bus.imem_addr_o, bus.instr_o, bus.instr_pc_waddr_o} !== 92'h0) begin n_fail++; $display("FAIL reset_regs got addr %h instr %h pc %h exp 0", bus.imem_addr_o, bus.instr_o, bus.instr_pc_waddr_o); end
  endtask

  task automatic test_first_fetch();
    rst = 1'b0; bus.fetch_en_i = 1'b1;
    #1;
    n_checks++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", bus.imem_req_o); end
    cyc();
    bus.imem_gnt_i = 1'b1;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 30'h100}) begin n_fail++; $display("FAIL first_req got req %b addr %h exp 1 100", bus.imem_req_o, bus.imem_addr_o); end
    cyc();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h00500093;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.instr_valid_o} !== 2'b00) begin n_fail++; $display("FAIL wait_ctrl got %b exp 00", {bus.imem_req_o, bus.instr_valid_o}); end
    cyc();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if ({bus.instr_valid_o, bus.pc_incr_o, bus.instr_o, bus.instr_pc_waddr_o} !== {2'b10, 32'h00500093, 30'h100}) begin n_fail++; $display("FAIL first_instr got v %b inc %b instr %h pc %h exp 1 0 00500093 100", bus.instr_valid_o, bus.pc_incr_o, bus.instr_o, bus.instr_pc_waddr_o); end
  endtask

  task automatic test_stream();
    logic [29:0] pc;
    pc = 30'h100;
    bus.instr_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (bus.pc_incr_o !== 1'b1) begin n_fail++; $display("FAIL stream_incr%0d got %b exp 1", k, bus.pc_incr_o); end
      cyc();
      pc = pc + 30'd1; bus.pc_waddr_i = pc; bus.next_pc_waddr_i = pc + 30'd1;
      bus.imem_gnt_i = 1'b1;
      #1;
      n_checks++; if ({bus.imem_req_o, bus.imem_addr_o, bus.pc_incr_o, bus.instr_valid_o} !== {1'b1, pc, 2'b00}) begin n_fail++; $display("FAIL stream_req%0d got req %b addr %h inc %b v %b exp 1 %h 0 0", k, bus.imem_req_o, bus.imem_addr_o, bus.pc_incr_o, bus.instr_valid_o, pc); end
      cyc();
      bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hA000_0000 + 32'(k);
      cyc();
      bus.imem_rvalid_i = 1'b0;
      #1;
      n_checks++; if ({bus.instr_valid_o, bus.instr_o, bus.instr_pc_waddr_o} !== {1'b1, 32'hA000_0000 + 32'(k), pc}) begin n_fail++; $display("FAIL stream_instr%0d got v %b instr %h pc %h exp 1 %h %h", k, bus.instr_valid_o, bus.instr_o, bus.instr_pc_waddr_o, 32'hA000_0000 + 32'(k), pc); end
    end
  endtask

  task automatic test_gnt_delay();
    cyc();
    bus.pc_waddr_i = 30'h103; bus.next_pc_waddr_i = 30'h104;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if ({bus.imem_req_o, bus.imem_addr_o, bus.pc_incr_o} !== {1'b1, 30'h103, 1'b0}) begin n_fail++; $display("FAIL gnt_hold%0d got req %b addr %h inc %b exp 1 103 0", k, bus.imem_req_o, bus.imem_addr_o, bus.pc_incr_o); end
      cyc();
    end
    bus.imem_gnt_i = 1'b1;
    cyc();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h1111_2222; bus.instr_ready_i = 1'b0;
    cyc();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if ({bus.instr_valid_o, bus.instr_o, bus.instr_pc_waddr_o, bus.pc_incr_o} !== {1'b1, 32'h1111_2222, 30'h103, 1'b0}) begin n_fail++; $display("FAIL gnt_instr got v %b instr %h pc %h inc %b exp 1 11112222 103 0", bus.instr_valid_o, bus.instr_o, bus.instr_pc_waddr_o, bus.pc_incr_o); end
  endtask

  task automatic test_flush_wait();
    bus.instr_ready_i = 1'b1;
    cyc();
    bus.instr_ready_i = 1'b0; bus.pc_waddr_i = 30'h104; bus.next_pc_waddr_i = 30'h105; bus.imem_gnt_i = 1'b1;
    cyc();
    bus.imem_gnt_i = 1'b0; bus.flush_i = 1'b1; bus.pc_waddr_i = 30'h200; bus.next_pc_waddr_i = 30'h201;
    cyc();
    bus.flush_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.instr_valid_o} !== 2'b00) begin n_fail++; $display("FAIL discard_ctrl got %b exp 00", {bus.imem_req_o, bus.instr_valid_o}); end
    cyc();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.instr_valid_o} !== 2'b00) begin n_fail++; $display("FAIL flush_drop got %b exp 00", {bus.imem_req_o, bus.instr_valid_o}); end
    cyc();
    bus.imem_gnt_i = 1'b1;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 30'h200}) begin n_fail++; $display("FAIL flush_target got req %b addr %h exp 1 200", bus.imem_req_o, bus.imem_addr_o); end
    cyc();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0000_0200;
    cyc();
    bus.imem_rvalid_i = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if ({bus.instr_valid_o, bus.imem_req_o, bus.pc_incr_o, bus.instr_o, bus.instr_pc_waddr_o} !== {3'b100, 32'h0000_0200, 30'h200}) begin n_fail++; $display("FAIL hold%0d got v %b req %b inc %b instr %h pc %h exp 1 0 0 00000200 200", k, bus.instr_valid_o, bus.imem_req_o, bus.pc_incr_o, bus.instr_o, bus.instr_pc_waddr_o); end
      cyc();
    end
    bus.instr_ready_i = 1'b1; bus.flush_i = 1'b1; bus.pc_waddr_i = 30'h300; bus.next_pc_waddr_i = 30'h301;
    #1;
    n_checks++; if ({bus.instr_valid_o, bus.pc_incr_o} !== 2'b10) begin n_fail++; $display("FAIL flush_accept got v %b inc %b exp 1 0", bus.instr_valid_o, bus.pc_incr_o); end
    cyc();
    bus.instr_ready_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    n_checks++; if ({bus.instr_valid_o, bus.imem_req_o} !== 2'b00) begin n_fail++; $display("FAIL flush_valid_low got %b exp 00", {bus.instr_valid_o, bus.imem_req_o}); end
    cyc();
    #1;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 30'h300}) begin n_fail++; $display("FAIL refetch got req %b addr %h exp 1 300", bus.imem_req_o, bus.imem_addr_o); end
  endtask

  task automatic test_reset_mid();
    bus.imem_gnt_i = 1'b1;
    cyc();
    bus.imem_gnt_i = 1'b0; rst = 1'b1; bus.pc_waddr_i = 30'h180; bus.next_pc_waddr_i = 30'h181;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.instr_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_wait_ctrl got %b exp 00", {bus.imem_req_o, bus.instr_valid_o}); end
    cyc();
    rst = 1'b0;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.instr_valid_o, bus.imem_addr_o} !== {2'b00, 30'h0}) begin n_fail++; $display("FAIL rst_idle got req %b v %b addr %h exp 0 0 0", bus.imem_req_o, bus.instr_valid_o, bus.imem_addr_o); end
    cyc();
    bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hBAD0_BAD0;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 30'h180}) begin n_fail++; $display("FAIL rst_fresh_req got req %b addr %h exp 1 180", bus.imem_req_o, bus.imem_addr_o); end
    cyc();
    bus.imem_rvalid_i = 1'b0; bus.imem_gnt_i = 1'b1;
    #1;
    n_checks++; if ({bus.imem_req_o, bus.instr_valid_o, bus.imem_addr_o} !== {2'b10, 30'h180}) begin n_fail++; $display("FAIL stray_rvalid got req %b v %b addr %h exp 1 0 180", bus.imem_req_o, bus.instr_valid_o, bus.imem_addr_o); end
    cyc();
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'h0018_0000;
    cyc();
    bus.imem_rvalid_i = 1'b0;
    #1;
    n_checks++; if ({bus.instr_valid_o, bus.instr_o, bus.instr_pc_waddr_o} !== {1'b1, 32'h0018_0000, 30'h180}) begin n_fail++; $display("FAIL rst_instr got v %b instr %h pc %h exp 1 00180000 180", bus.instr_valid_o, bus.instr_o, bus.instr_pc_waddr_o); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stream();
    test_gnt_delay();
    test_flush_wait();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
